wallace_divider_64: RTL

- Sequential restoring divider that inverts `Wallace_multiplier_64`: takes a 64-bit dividend (a product) and a 32-bit divisor.
- Returns the 32-bit quotient and the 32-bit remainder.
- Sits beside the multiplier in the modexp datapath and serves the modular-reduction steps.
- Start/busy/done handshake; one quotient bit resolved per clock.

---
 rtl/wallace_divider_64.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/wallace_divider_64.sv
// ---------------------------------------------------------------------------
// wallace_divider_64
//
// Sequential restoring divider, the inverse of the 64-bit product built by
// the Wallace multiplier in the modexp datapath.
// It divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and resolves one
// quotient bit per clock.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   start      request pulse, sampled only while idle
//   dividend   2*WIDTH-bit numerator, captured when start is accepted
//   divisor    WIDTH-bit denominator, captured when start is accepted
//   busy       high whenever the block is not idle
//   done       one-cycle pulse; the results are valid from this cycle on
//   quotient   registered quotient
//   remainder  registered remainder
//   div_zero   the last operation had divisor == 0
//   overflow   the last operation's quotient would not fit in WIDTH bits
// ---------------------------------------------------------------------------
module wallace_divider_64 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Partial remainder. The logical register is WIDTH+1 bits wide, but the
  // invariant R < D keeps its top bit at zero between steps, so only the
  // low WIDTH bits are stored. The extra bit exists only in r_shift / diff.
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             div_zero_reg, div_zero_next;
  logic             overflow_reg, overflow_next;

  // One restoring step
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  logic             is_zero;
  logic             is_ovf;

  assign is_zero = (divisor == '0);
  assign is_ovf  = (dividend[2*WIDTH-1:WIDTH] >= divisor);

  // Shift {R,Q} left by one, then try to subtract D. A negative difference
  // (MSB set) means D did not fit, so the shifted value is kept as it is.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_reg};
  assign r_step  = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_step  = {q_reg[WIDTH-2:0], ~diff[WIDTH]};

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // Error cases skip the iteration and report in the next cycle.
          if (is_zero || is_ovf) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (cnt_reg == LAST_STEP) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy = (state_reg != ST_IDLE);
    done = (state_reg == ST_DONE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    r_next         = r_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    div_zero_next  = div_zero_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          d_next        = divisor;
          r_next        = dividend[2*WIDTH-1:WIDTH];
          q_next        = dividend[WIDTH-1:0];
          cnt_next      = '0;
          div_zero_next = 1'b0;
          overflow_next = 1'b0;
          if (is_zero) begin
            div_zero_next  = 1'b1;
            quotient_next  = '1;
            remainder_next = dividend[WIDTH-1:0];
          end else if (is_ovf) begin
            overflow_next  = 1'b1;
            quotient_next  = '1;
            remainder_next = '0;
          end
        end
      end
      ST_CALC: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_STEP) begin
          quotient_next  = q_step;
          remainder_next = r_step;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      r_reg         <= r_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      div_zero_reg  <= div_zero_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;
  assign overflow  = overflow_reg;

endmodule
